// File: rtl/yuv422_unpack_pkg.sv
// yuv_pkg: shared definitions for the YUV 4:2:2 unpacker.
//   phase_t      - byte position inside a 4-byte pixel-pair group (B0..B3)
//   ORDER_UYVY   - BYTE_ORDER value for U,Y0,V,Y1 packing
//   ORDER_YUYV   - BYTE_ORDER value for Y0,U,Y1,V packing
//   PIX_W        - width of one component byte
//   next_phase() - B0->B1->B2->B3->B0 step
package yuv_pkg;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2,
        B3 = 2'd3
    } phase_t;

    localparam int ORDER_UYVY = 0;
    localparam int ORDER_YUYV = 1;
    localparam int PIX_W      = 8;

    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/yuv422_unpack_if.sv
// Interfaces for yuv422_unpack.
//   yuv422_cam_if : camera byte stream (vsync, href, de, din).
//                   master = camera side, slave = unpacker.
//   yuv422_pix_if : per-pixel output (Y, U, V, pix_valid, sof, eol, err,
//                   plus px/py when YUV422_PIX_COORD_EN is defined).
//                   master = unpacker, slave = downstream consumer.
interface yuv422_cam_if;
    import yuv_pkg::*;

    logic             vsync;
    logic             href;
    logic             de;
    logic [PIX_W-1:0] din;

    modport master (output vsync, href, de, din);
    modport slave  (input  vsync, href, de, din);
endinterface

interface yuv422_pix_if
`ifdef YUV422_PIX_COORD_EN
    #(parameter int X_W = 10, parameter int Y_W = 9)
`endif
    ;
    import yuv_pkg::*;

    logic [PIX_W-1:0] Y;
    logic [PIX_W-1:0] U;
    logic [PIX_W-1:0] V;
    logic             pix_valid;
    logic             sof;
    logic             eol;
    logic             err;
`ifdef YUV422_PIX_COORD_EN
    logic [X_W-1:0]   px;
    logic [Y_W-1:0]   py;
`endif

`ifdef YUV422_PIX_COORD_EN
    modport master (output Y, U, V, pix_valid, sof, eol, err, px, py);
    modport slave  (input  Y, U, V, pix_valid, sof, eol, err, px, py);
`else
    modport master (output Y, U, V, pix_valid, sof, eol, err);
    modport slave  (input  Y, U, V, pix_valid, sof, eol, err);
`endif
endinterface

// File: rtl/yuv422_unpack.sv
// yuv422_unpack: packed 8-bit YUV 4:2:2 byte stream -> one Y/U/V triple
// per pixel, chroma shared across each pixel pair.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-low reset
//   cam  - yuv422_cam_if.slave : vsync, href, de, din
//   pix  - yuv422_pix_if.master: Y, U, V, pix_valid, sof, eol, err
//                                (+ px, py with YUV422_PIX_COORD_EN)
//
// Parameters:
//   BYTE_ORDER - 0 = UYVY, 1 = YUYV
//   X_W, Y_W   - column / line counter widths (coordinate feature only)
//
// Optional feature: define YUV422_PIX_COORD_EN to add px/py coordinate
// outputs aligned with pix_valid.
//
// All outputs are registered; a pixel appears exactly one cycle after the
// strobe edge of the byte that completes it. Y/U/V hold between pixels.
module yuv422_unpack
    import yuv_pkg::*;
#(
    parameter int BYTE_ORDER = 0,
    parameter int X_W        = 10,
    parameter int Y_W        = 9
) (
    input  logic         clk,
    input  logic         rst,
    yuv422_cam_if.slave  cam,
    yuv422_pix_if.master pix
);

    generate
        if ((BYTE_ORDER != ORDER_UYVY && BYTE_ORDER != ORDER_YUYV) || X_W < 1 || Y_W < 1) begin : g_bad_cfg
            $error("yuv422_unpack: BYTE_ORDER must be 0 or 1, X_W/Y_W must be >= 1");
        end
    endgenerate

    localparam bit YUYV = (BYTE_ORDER == ORDER_YUYV);

    phase_t           phase;
    logic [PIX_W-1:0] u_r, v_r, y0_r, y1_r;
    logic             pend;       // YUYV second pixel owed next cycle
    logic             sof_armed;
    logic             href_d;

    logic accept;
    logic fall;
    assign accept = cam.de & cam.href & ~cam.vsync;
    assign fall   = href_d & ~cam.href;

    // Which pixel (if any) is produced by this cycle's inputs.
    logic             emit;
    logic [PIX_W-1:0] e_y, e_u, e_v;

    always_comb begin
        emit = 1'b0;
        e_y  = y0_r;
        e_u  = u_r;
        e_v  = v_r;
        if (pend) begin
            // pend is only set by a B3 byte, so phase is B0 now and no
            // accepted byte this cycle can also complete a pixel.
            emit = 1'b1;
            e_y  = y1_r;
        end else if (accept) begin
            if (!YUYV) begin
                if (phase == B2) begin
                    emit = 1'b1;
                    e_v  = cam.din;
                end else if (phase == B3) begin
                    emit = 1'b1;
                    e_y  = cam.din;
                end
            end else if (phase == B3) begin
                emit = 1'b1;
                e_v  = cam.din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase         <= B0;
            u_r           <= '0;
            v_r           <= '0;
            y0_r          <= '0;
            y1_r          <= '0;
            pend          <= 1'b0;
            sof_armed     <= 1'b1;
            href_d        <= 1'b0;
            pix.Y         <= '0;
            pix.U         <= '0;
            pix.V         <= '0;
            pix.pix_valid <= 1'b0;
            pix.sof       <= 1'b0;
            pix.eol       <= 1'b0;
            pix.err       <= 1'b0;
        end else begin
            href_d        <= cam.href;
            pix.pix_valid <= emit;
            pix.eol       <= fall & ~cam.vsync;
            // A nonzero phase at the fall means a partial group is dropped.
            pix.err       <= fall & ~cam.vsync & (phase != B0);
            pend          <= accept & YUYV & (phase == B3);

            if (emit) begin
                pix.Y     <= e_y;
                pix.U     <= e_u;
                pix.V     <= e_v;
                pix.sof   <= sof_armed;
                sof_armed <= 1'b0;
            end else begin
                pix.sof   <= 1'b0;
            end
            if (cam.vsync)
                sof_armed <= 1'b1;

            if (accept) begin
                if (!YUYV) begin
                    case (phase)
                        B0:      u_r  <= cam.din;
                        B1:      y0_r <= cam.din;
                        B2:      v_r  <= cam.din;
                        default: ;
                    endcase
                end else begin
                    case (phase)
                        B0:      y0_r <= cam.din;
                        B1:      u_r  <= cam.din;
                        B2:      y1_r <= cam.din;
                        default: v_r  <= cam.din;
                    endcase
                end
            end

            // Outside an active line the group always restarts at B0.
            if (cam.vsync || !cam.href)
                phase <= B0;
            else if (accept)
                phase <= next_phase(phase);
        end
    end

`ifdef YUV422_PIX_COORD_EN
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            pix.px <= '0;
            pix.py <= '0;
        end else begin
            if (emit) begin
                pix.px <= x_cnt;
                pix.py <= y_cnt;
                x_cnt  <= x_cnt + 1'b1;
            end
            // A pend pixel landing on the fall cycle still takes the old
            // column; the clear below wins over the increment.
            if (fall || cam.vsync)
                x_cnt <= '0;
            if (cam.vsync)
                y_cnt <= '0;
            else if (fall)
                y_cnt <= y_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_yuv422_unpack.sv
// Self-checking bench for yuv422_unpack. Both byte orders are instantiated
// on the same camera stream; a group-level reference model predicts every
// cycle's outputs for each instance.
module tb_yuv422_unpack;
    import yuv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    yuv422_cam_if cam ();
    yuv422_pix_if pix0 ();
    yuv422_pix_if pix1 ();

    yuv422_unpack #(.BYTE_ORDER(0)) dut0 (.clk(clk), .rst(rst), .cam(cam), .pix(pix0));
    yuv422_unpack #(.BYTE_ORDER(1)) dut1 (.clk(clk), .rst(rst), .cam(cam), .pix(pix1));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model state
    logic [7:0]  grp[$];          // accepted bytes of current group
    logic        defer_v;
    logic [23:0] defer_pix;       // YUYV second pixel, {Y,U,V}
    logic        armed[2];
    logic [23:0] held[2];
    logic        pv_e[2];
    logic        sof_e[2];
    logic        eol_e, err_e;
    logic        prev_href;

    // observed event counters
    int pv_cnt[2];
    int sof_cnt[2];
    int eol_cnt, err_cnt;

    // pixel capture for gap-vs-continuous comparison
    int          cap_sel = 0;
    logic [23:0] qa[$];
    logic [23:0] qb[$];

    task automatic model_reset();
        grp.delete();
        defer_v   = 1'b0;
        defer_pix = '0;
        prev_href = 1'b0;
        eol_e     = 1'b0;
        err_e     = 1'b0;
        for (int o = 0; o < 2; o++) begin
            armed[o] = 1'b1;
            held[o]  = '0;
            pv_e[o]  = 1'b0;
            sof_e[o] = 1'b0;
        end
    endtask

    task automatic emit(input int o, input logic [23:0] p);
        pv_e[o]  = 1'b1;
        held[o]  = p;
        sof_e[o] = armed[o];
        armed[o] = 1'b0;
    endtask

    // Apply the spec's rules to the inputs seen at the last clock edge.
    task automatic model_edge();
        logic fall, acc;
        for (int o = 0; o < 2; o++) begin
            pv_e[o]  = 1'b0;
            sof_e[o] = 1'b0;
        end
        eol_e = 1'b0;
        err_e = 1'b0;
        if (!rst) begin
            model_reset();
            return;
        end
        fall = prev_href & ~cam.href;
        acc  = cam.de & cam.href & ~cam.vsync;
        if (defer_v) begin
            emit(1, defer_pix);
            defer_v = 1'b0;
        end
        if (acc) begin
            grp.push_back(cam.din);
            if (grp.size() == 3)
                emit(0, {grp[1], grp[0], grp[2]});
            if (grp.size() == 4) begin
                emit(0, {grp[3], grp[0], grp[2]});
                emit(1, {grp[0], grp[1], grp[3]});
                defer_v   = 1'b1;
                defer_pix = {grp[2], grp[1], grp[3]};
                grp.delete();
            end
        end
        eol_e = fall & ~cam.vsync;
        err_e = eol_e & (grp.size() != 0);
        if (cam.vsync || !cam.href)
            grp.delete();
        if (cam.vsync) begin
            armed[0] = 1'b1;
            armed[1] = 1'b1;
        end
        prev_href = cam.href;
    endtask

    task automatic check(input string tag);
        logic [27:0] o0, o1, e0, e1;
        o0 = {pix0.pix_valid, pix0.sof, pix0.eol, pix0.err, pix0.Y, pix0.U, pix0.V};
        o1 = {pix1.pix_valid, pix1.sof, pix1.eol, pix1.err, pix1.Y, pix1.U, pix1.V};
        e0 = {pv_e[0], sof_e[0], eol_e, err_e, held[0]};
        e1 = {pv_e[1], sof_e[1], eol_e, err_e, held[1]};
        n_cmp++;
        assert (o0 === e0) else begin
            n_bad++;
            $error("FAIL %s/uyvy cyc=%0d got={pv,sof,eol,err,YUV}=%h want=%h", tag, cyc, o0, e0);
        end
        n_cmp++;
        assert (o1 === e1) else begin
            n_bad++;
            $error("FAIL %s/yuyv cyc=%0d got={pv,sof,eol,err,YUV}=%h want=%h", tag, cyc, o1, e1);
        end
        pv_cnt[0]  += int'(pix0.pix_valid);
        pv_cnt[1]  += int'(pix1.pix_valid);
        sof_cnt[0] += int'(pix0.sof);
        sof_cnt[1] += int'(pix1.sof);
        eol_cnt    += int'(pix0.eol);
        err_cnt    += int'(pix0.err);
        if (pix0.pix_valid && cap_sel == 1) qa.push_back({pix0.Y, pix0.U, pix0.V});
        if (pix0.pix_valid && cap_sel == 2) qb.push_back({pix0.Y, pix0.U, pix0.V});
    endtask

    task automatic cnt_check(input string tag, input int got, input int want);
        n_cmp++;
        assert (got == want) else begin
            n_bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic step(input logic vs, input logic hr, input logic d, input logic [7:0] b, input string tag);
        cam.vsync = vs;
        cam.href  = hr;
        cam.de    = d;
        cam.din   = b;
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        check(tag);
    endtask

    // Send one line; gaps=1 toggles de with random extra idle cycles.
    task automatic send_line(input logic [7:0] bytes[$], input bit gaps, input string tag);
        foreach (bytes[i]) begin
            if (gaps) begin
                int n = 1 + int'($urandom_range(0, 2));
                for (int g = 0; g < n; g++)
                    step(1'b0, 1'b1, 1'b0, 8'($urandom), tag);
            end
            step(1'b0, 1'b1, 1'b1, bytes[i], tag);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, tag);
        step(1'b0, 1'b0, 1'b0, 8'h00, tag);
    endtask

    task automatic vsync_pulse(input string tag);
        step(1'b1, 1'b0, 1'b0, 8'h00, tag);
        step(1'b1, 1'b0, 1'b0, 8'h00, tag);
        step(1'b0, 1'b0, 1'b0, 8'h00, tag);
    endtask

    function automatic void rand_line(output logic [7:0] q[$], input int nbytes);
        q.delete();
        for (int i = 0; i < nbytes; i++)
            q.push_back(8'($urandom));
    endfunction

    initial begin
        logic [7:0] ln[$];
        int p0, p1, s0, s1, e0, r0;

        cam.vsync = 1'b0;
        cam.href  = 1'b0;
        cam.de    = 1'b0;
        cam.din   = 8'h00;
        pv_cnt  = '{0, 0};
        sof_cnt = '{0, 0};
        eol_cnt = 0;
        err_cnt = 0;
        model_reset();

        // reset state
        step(1'b0, 1'b0, 1'b0, 8'h00, "reset");
        step(1'b0, 1'b1, 1'b1, 8'h55, "reset");
        rst = 1'b1;
        vsync_pulse("vs0");

        // UYVY pattern (also drives YUYV instance)
        p0 = pv_cnt[0]; p1 = pv_cnt[1];
        ln = '{8'h80, 8'h10, 8'h90, 8'h20};
        send_line(ln, 1'b0, "uyvy_line");
        cnt_check("uyvy_line_pv0", pv_cnt[0] - p0, 2);
        cnt_check("uyvy_line_pv1", pv_cnt[1] - p1, 2);

        // YUYV pattern, href drops right after byte 4: no err
        r0 = err_cnt; e0 = eol_cnt;
        ln = '{8'h10, 8'h80, 8'h20, 8'h90};
        send_line(ln, 1'b0, "yuyv_line");
        cnt_check("yuyv_line_err", err_cnt - r0, 0);
        cnt_check("yuyv_line_eol", eol_cnt - e0, 1);

        // frame: vsync, 2 lines of 4 pixels
        vsync_pulse("vs1");
        p0 = pv_cnt[0]; p1 = pv_cnt[1];
        s0 = sof_cnt[0]; s1 = sof_cnt[1]; e0 = eol_cnt;
        for (int l = 0; l < 2; l++) begin
            rand_line(ln, 8);
            send_line(ln, 1'b0, "frame");
        end
        cnt_check("frame_pv0", pv_cnt[0] - p0, 8);
        cnt_check("frame_pv1", pv_cnt[1] - p1, 8);
        cnt_check("frame_sof0", sof_cnt[0] - s0, 1);
        cnt_check("frame_sof1", sof_cnt[1] - s1, 1);
        cnt_check("frame_eol", eol_cnt - e0, 2);

        // href falls after 3 bytes
        p0 = pv_cnt[0]; p1 = pv_cnt[1]; r0 = err_cnt; e0 = eol_cnt;
        ln = '{8'h80, 8'h10, 8'h90};
        send_line(ln, 1'b0, "short");
        cnt_check("short_pv0", pv_cnt[0] - p0, 1);
        cnt_check("short_pv1", pv_cnt[1] - p1, 0);
        cnt_check("short_err", err_cnt - r0, 1);
        cnt_check("short_eol", eol_cnt - e0, 1);
        ln = '{8'h81, 8'h11, 8'h91, 8'h21};
        send_line(ln, 1'b0, "after_short");

        // de gaps: same bytes with and without gaps give identical pixels
        for (int t = 0; t < 3; t++) begin
            rand_line(ln, 4 * (1 + int'($urandom_range(0, 3))));
            qa.delete(); qb.delete();
            cap_sel = 1;
            send_line(ln, 1'b0, "cont");
            cap_sel = 2;
            send_line(ln, 1'b1, "gaps");
            cap_sel = 0;
            cnt_check("gap_npix", qb.size(), qa.size());
            foreach (qa[i]) begin
                n_cmp++;
                assert (i < qb.size() && qb[i] === qa[i]) else begin
                    n_bad++;
                    $error("FAIL gap_pix[%0d] got=%h want=%h", i, (i < qb.size()) ? qb[i] : 24'hx, qa[i]);
                end
            end
        end

        // async reset mid-group
        step(1'b0, 1'b1, 1'b1, 8'h33, "rst_mid");
        step(1'b0, 1'b1, 1'b1, 8'h44, "rst_mid");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_async");
        step(1'b0, 1'b1, 1'b1, 8'h66, "rst_hold");
        step(1'b0, 1'b0, 1'b0, 8'h00, "rst_hold");
        rst = 1'b1;
        s0 = sof_cnt[0]; s1 = sof_cnt[1];
        ln = '{8'h82, 8'h12, 8'h92, 8'h22};
        send_line(ln, 1'b0, "post_rst");
        cnt_check("post_rst_sof0", sof_cnt[0] - s0, 1);
        cnt_check("post_rst_sof1", sof_cnt[1] - s1, 1);

        // random soak: arbitrary framing, strobes and data
        begin
            logic hr = 1'b0;
            for (int i = 0; i < 600; i++) begin
                logic vs;
                vs = ($urandom_range(0, 40) == 0);
                if ($urandom_range(0, 15) == 0) hr = ~hr;
                step(vs, hr, 1'($urandom_range(0, 3) != 0), 8'($urandom), "soak");
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, "tail");
        step(1'b0, 1'b0, 1'b0, 8'h00, "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/yuv422_unpack.md
Name: yuv422_unpack

Overview:
- Camera-side front end. Converts an 8-bit packed YUV 4:2:2 byte stream (href/vsync framed, byte-strobed) into one full Y/U/V triple per pixel.
- Output is a single-cycle valid pulse per pixel, sized to drive the downstream YUV-to-RGB converter directly: Y, U, V to its Y, U, V inputs, pix_valid to its valid.
- Chroma is shared by each pixel pair. Framing flags travel alongside the pixels.

Parameters:
- BYTE_ORDER, 0, packing order: 0 = UYVY (U,Y0,V,Y1); 1 = YUYV (Y0,U,Y1,V).
- X_W, 10, width of the pixel-column counter (optional feature only).
- Y_W, 9, width of the line counter (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- vsync  in  1  frame sync, active high; high = inter-frame blanking
- href  in  1  line active, active high
- de  in  1  byte strobe; din sampled only when de=1 and href=1
- din  in  8  packed YUV byte
- Y  out  8  luma of emitted pixel
- U  out  8  Cb of emitted pixel
- V  out  8  Cr of emitted pixel
- pix_valid  out  1  one-cycle pulse, Y/U/V valid
- sof  out  1  high with pix_valid on first pixel of a frame
- eol  out  1  one-cycle pulse, cycle after href falls
- err  out  1  one-cycle pulse, line ended mid pixel pair

Behaviour:
- Reset: Y/U/V=0; pix_valid, sof, eol, err=0; phase=B0; sof_armed=1; pend=0.
- Phase FSM B0→B1→B2→B3→B0. It advances only on an accepted byte (de & href & !vsync).
- Capture rules, UYVY:
  - B0 latch U.
  - B1 latch Y0.
  - B2 latch V; pixel (Y0,U,din) emitted next cycle.
  - B3: pixel (din,U,V) emitted next cycle.
- Capture rules, YUYV:
  - B0 latch Y0.
  - B1 latch U.
  - B2 latch Y1.
  - B3: pixel (Y0,U,din) emitted next cycle; pend=1.
  - The following cycle, pixel (Y1,U,V) is emitted unconditionally and pend clears. This pixel does not depend on de, href or a new byte.
  - An accepted byte arriving while pend=1 is latched normally. There is no output conflict because its B0 produces no pixel.
- Latency: pix_valid registered, exactly 1 cycle after the completing byte's strobe edge. Outputs hold their last value while pix_valid=0.
- sof: ANDed with the first pix_valid after sof_armed. That pixel clears sof_armed; vsync=1 sets it.
- href falling:
  - eol pulses next cycle.
  - If phase≠B0 at the fall, err pulses with eol; phase returns to B0 and the partial group is discarded. No pixel is emitted from it, except an already scheduled pend pixel.
- vsync=1: phase forced to B0; bytes are ignored; pend still completes; eol and err are not generated.
- Simultaneous href fall and completing byte: the byte is not accepted (href=0), so the group is incomplete and err fires.
- de gaps inside a group: the phase is held indefinitely; no timeout.
- Async reset mid-group: everything returns to reset values immediately; the partial group is lost.

Optional Feature:
- Macro YUV422_PIX_COORD_EN.
- When defined, adds outputs px (X_W) and py (Y_W), registered and aligned with pix_valid:
  - px = column of emitted pixel; 0 at line start, +1 per pix_valid; cleared on eol.
  - py = line index; 0 for the first line after vsync; +1 on each eol; cleared while vsync=1.
  - Both counters wrap modulo 2^width silently.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package yuv_pkg: phase encoding B0..B3 (2-bit), constants ORDER_UYVY=0 and ORDER_YUYV=1, pixel byte width 8.
- Single module, no sub-module. The optional coordinate counters are about 30 lines inline and not worth a separate block.

Test Plan:
- UYVY, one line of bytes 0x80,0x10,0x90,0x20 (de=1 every cycle):
  - pixel (Y=0x10,U=0x80,V=0x90) one cycle after the 3rd byte;
  - pixel (0x20,0x80,0x90) one cycle after the 4th byte;
  - pix_valid high exactly 2 cycles.
- YUYV, bytes 0x10,0x80,0x20,0x90:
  - pixels (0x10,0x80,0x90) and (0x20,0x80,0x90) on consecutive cycles after the 4th byte;
  - same result with href dropped right after byte 4: no err.
- Frame: vsync pulse, then 2 lines of 4 pixels each:
  - sof only on pixel 0 of line 0;
  - eol twice, one cycle after each href fall;
  - 8 pix_valid total.
- href falls after 3 bytes (UYVY):
  - one pixel emitted;
  - err and eol together;
  - next line decodes correctly from B0.
- de toggled 1/0 every cycle with random extra gaps:
  - output pixel values identical to the continuous-de case;
  - latency 1 cycle from each completing strobe.
- rst low after 2 bytes, then released:
  - all outputs 0 during reset;
  - next line decodes from B0;
  - sof re-armed.
